// File: rtl/simon_game_fsm.sv
// SIMON game sequencer: grows a random colour sequence, plays it back, checks the
// player's presses and drives the colour/screen code consumed by block_controller.
module simon_game_fsm #(
  parameter int unsigned TICKS_ON   = 50_000_000,
  parameter int unsigned TICKS_OFF  = 25_000_000,
  parameter int unsigned TICKS_ECHO = 25_000_000,
  parameter int unsigned TIMEOUT    = 500_000_000,
  parameter int unsigned MAX_LEN    = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sw_en,
  input  logic       i_sw_play,
  input  logic       i_btnu,
  input  logic       i_btnr,
  input  logic       i_btnd,
  input  logic       i_btnl,
  output logic [3:0] o_gColorNum,
  output logic [4:0] o_level,
  output logic       o_won,
  output logic       o_lost
);

  localparam int LW = 5;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0]   ON_LAST   = 32'(TICKS_ON - 1);
  localparam logic [31:0]   OFF_LAST  = 32'(TICKS_OFF - 1);
  localparam logic [31:0]   ECHO_LAST = 32'(TICKS_ECHO - 1);
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [LW-1:0] MAX_LV    = LW'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_ADD, S_SHOW_ON, S_SHOW_OFF,
    S_INPUT, S_ECHO, S_GAP, S_LOSE, S_WIN
  } state_t;

  state_t      r_state, w_stateNext;
  logic [31:0] r_timer;
  logic [LW-1:0] r_idx, r_level, w_idxNext, w_levelNext;
  logic [1:0]  r_seq [MAX_LEN];
  logic [15:0] r_lfsr;
  logic [3:0]  r_echo, w_echoNext, w_colorNext, w_pressColor, w_expColor, w_showColor;
  logic [1:0]  w_showCode;
  logic        w_anyPress, w_seqWr, w_lastIdx, w_lfsrFb;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form
  assign w_lfsrFb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_anyPress = i_btnu | i_btnr | i_btnd | i_btnl;
  assign w_expColor = {2'b00, r_seq[r_idx[IW-1:0]]} + 4'd1;
  assign w_lastIdx  = (r_idx == r_level - LW'(1));

  always_comb begin
    w_pressColor = 4'd0;
    if (i_btnu)      w_pressColor = 4'd1;
    else if (i_btnr) w_pressColor = 4'd2;
    else if (i_btnd) w_pressColor = 4'd3;
    else if (i_btnl) w_pressColor = 4'd4;
  end

  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_levelNext = r_level;
    w_seqWr     = 1'b0;
    case (r_state)
      S_IDLE: if (i_sw_en) w_stateNext = S_INIT;
      S_INIT: if (i_sw_play) w_stateNext = S_ADD;
      S_ADD: begin
        w_seqWr     = 1'b1;
        w_levelNext = r_level + LW'(1);
        w_idxNext   = '0;
        w_stateNext = S_SHOW_ON;
      end
      S_SHOW_ON: if (r_timer == ON_LAST) w_stateNext = S_SHOW_OFF;
      S_SHOW_OFF: begin
        if (r_timer == OFF_LAST) begin
          if (w_lastIdx) begin
            w_idxNext   = '0;
            w_stateNext = S_INPUT;
          end else begin
            w_idxNext   = r_idx + LW'(1);
            w_stateNext = S_SHOW_ON;
          end
        end
      end
      // a press on the final timeout cycle takes precedence over the timeout
      S_INPUT: begin
        if (w_anyPress) begin
          w_stateNext = (w_pressColor == w_expColor) ? S_ECHO : S_LOSE;
        end else if (r_timer == TO_LAST) begin
          w_stateNext = S_LOSE;
        end
      end
      S_ECHO: begin
        if (r_timer == ECHO_LAST) begin
          if (!w_lastIdx) begin
            w_idxNext   = r_idx + LW'(1);
            w_stateNext = S_INPUT;
          end else if (r_level == MAX_LV) begin
            w_stateNext = S_WIN;
          end else begin
            w_stateNext = S_GAP;
          end
        end
      end
      S_GAP: if (r_timer == OFF_LAST) w_stateNext = S_ADD;
      S_LOSE, S_WIN: if (!i_sw_play) w_stateNext = S_INIT;
      default: w_stateNext = S_IDLE;
    endcase
    if (!i_sw_en) w_stateNext = S_IDLE;
  end

  // Outputs are registered from the next state; the colour just being added is
  // forwarded when playback starts at the slot written on the same edge.
  always_comb begin
    w_showCode  = (r_state == S_ADD && w_idxNext == r_level) ? r_lfsr[1:0]
                                                            : r_seq[w_idxNext[IW-1:0]];
    w_showColor = {2'b00, w_showCode} + 4'd1;
    w_echoNext  = (r_state == S_INPUT && w_anyPress) ? w_pressColor : r_echo;
    w_colorNext = 4'd0;
    case (w_stateNext)
      S_INIT, S_WIN: w_colorNext = 4'd7;
      S_SHOW_ON:     w_colorNext = w_showColor;
      S_ECHO:        w_colorNext = w_echoNext;
      S_LOSE:        w_colorNext = 4'd5;
      default:       w_colorNext = 4'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_level     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_echo      <= 4'd0;
      o_gColorNum <= 4'd0;
      o_won       <= 1'b0;
      o_lost      <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) r_seq[i] <= 2'd0;
    end else begin
      r_lfsr      <= {w_lfsrFb, r_lfsr[15:1]};
      r_state     <= w_stateNext;
      r_timer     <= (w_stateNext != r_state) ? 32'd0 : r_timer + 32'd1;
      r_idx       <= w_idxNext;
      r_level     <= (w_stateNext == S_INIT) ? '0 : w_levelNext;
      r_echo      <= w_echoNext;
      o_gColorNum <= w_colorNext;
      o_won       <= (w_stateNext == S_WIN);
      o_lost      <= (w_stateNext == S_LOSE);
      if (w_seqWr) r_seq[r_level[IW-1:0]] <= r_lfsr[1:0];
    end
  end

  assign o_level = r_level;

endmodule

// File: tb/tb_simon_game_fsm.sv
// Self-checking bench for simon_game_fsm: a game-level model (LFSR value per cycle,
// colour queue, phase durations) predicts every sampled output.
module tb_simon_game_fsm;

  localparam int TICKS_ON   = 4;
  localparam int TICKS_OFF  = 2;
  localparam int TICKS_ECHO = 3;
  localparam int TIMEOUT    = 20;
  localparam int MAX_LEN    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk, rst_n, swEn, swPlay, btnu, btnr, btnd, btnl;
  logic [3:0] gColorNum;
  logic [4:0] level;
  logic won, lost;

  int checkCount = 0;
  int errorCount = 0;
  logic [15:0] mdlLfsr;
  int mdlSeq[$];
  int mdlLevel;

  simon_game_fsm #(
    .TICKS_ON(TICKS_ON), .TICKS_OFF(TICKS_OFF), .TICKS_ECHO(TICKS_ECHO),
    .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_en(swEn), .i_sw_play(swPlay),
    .i_btnu(btnu), .i_btnr(btnr), .i_btnd(btnd), .i_btnl(btnl),
    .o_gColorNum(gColorNum), .o_level(level), .o_won(won), .o_lost(lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11
  function automatic logic [15:0] lfsrStep(input logic [15:0] x);
    logic fb;
    fb = x[0] ^ x[2] ^ x[3] ^ x[5];
    return (x >> 1) | (16'(fb) << 15);
  endfunction

  // Highest priority pressed button: bit0=up(1), bit1=right(2), bit2=down(3), bit3=left(4)
  function automatic int decodePress(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i + 1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCount++;
    if (obs != exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b);
    {btnl, btnd, btnr, btnu} = b;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) mdlLfsr = lfsrStep(mdlLfsr);
    #1;
  endtask

  // Next edge enters ADD; then plays back the whole sequence
  task automatic playRound();
    tick();
    mdlSeq.push_back(int'(mdlLfsr[1:0]) + 1);
    mdlLevel++;
    for (int i = 0; i < mdlLevel; i++) begin
      for (int k = 0; k < TICKS_ON; k++) begin
        tick();
        checkOutput("showColor", int'(gColorNum), mdlSeq[i]);
        if (i == 0 && k == 0) checkOutput("levelAfterAdd", int'(level), mdlLevel);
      end
      for (int k = 0; k < TICKS_OFF; k++) begin
        tick();
        checkOutput("showBlank", int'(gColorNum), 0);
      end
    end
  endtask

  // Enters INPUT, waits, presses b, then follows echo or loss
  task automatic echoPress(input int idx, input int delay, input logic [3:0] b, output bit ok);
    int c;
    tick();
    checkOutput("inputEntry", int'(gColorNum), 0);
    for (int k = 0; k < delay; k++) begin
      tick();
      checkOutput("inputWait", int'(gColorNum), 0);
    end
    applyStimulus(b);
    tick();
    applyStimulus(4'b0000);
    c = decodePress(b);
    if (c == mdlSeq[idx]) begin
      ok = 1'b1;
      checkOutput("echoColor", int'(gColorNum), c);
      for (int k = 1; k < TICKS_ECHO; k++) begin
        tick();
        checkOutput("echoHold", int'(gColorNum), c);
      end
    end else begin
      ok = 1'b0;
      checkOutput("loseColor", int'(gColorNum), 5);
      checkOutput("lostFlag", int'(lost), 1);
    end
  endtask

  task automatic playerTurn(input int errAt, output bit ok);
    logic [3:0] oh, lowMask, b;
    int c;
    ok = 1'b1;
    for (int i = 0; i < mdlLevel; i++) begin
      c = (i == errAt) ? (mdlSeq[i] % 4) + 1 : mdlSeq[i];
      oh = 4'(1 << (c - 1));
      lowMask = (oh << 1) - 4'd1;
      b = oh | (4'($urandom) & ~lowMask);
      echoPress(i, int'($urandom_range(0, 6)), b, ok);
      if (!ok) return;
    end
  endtask

  task automatic finishRound();
    if (mdlLevel == MAX_LEN) begin
      tick();
      checkOutput("winColor", int'(gColorNum), 7);
      checkOutput("wonFlag", int'(won), 1);
      checkOutput("winLevel", int'(level), MAX_LEN);
    end else begin
      for (int k = 0; k < TICKS_OFF; k++) begin
        tick();
        checkOutput("gapBlank", int'(gColorNum), 0);
      end
    end
  endtask

  task automatic enterInit();
    tick();
    checkOutput("initColor", int'(gColorNum), 7);
    checkOutput("initLevel", int'(level), 0);
    checkOutput("initLost", int'(lost), 0);
    mdlSeq.delete();
    mdlLevel = 0;
  endtask

  initial begin
    bit ok;
    int guard, errRound;
    logic [15:0] nxt;
    rst_n = 1'b0; swEn = 1'b0; swPlay = 1'b0;
    applyStimulus(4'b0000);
    mdlLfsr = SEED; mdlLevel = 0;
    #2;
    checkOutput("resetColor", int'(gColorNum), 0);
    checkOutput("resetLevel", int'(level), 0);
    checkOutput("resetWon", int'(won), 0);
    checkOutput("resetLost", int'(lost), 0);
    tick(); tick();
    rst_n = 1'b1; swEn = 1'b1;
    enterInit();

    $display("[TB] reset during playback");
    swPlay = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midResetColor", int'(gColorNum), 0);
    checkOutput("midResetLevel", int'(level), 0);
    checkOutput("midResetWon", int'(won), 0);
    checkOutput("midResetLost", int'(lost), 0);
    mdlLfsr = SEED;
    swPlay = 1'b0; swEn = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    checkOutput("idleColor", int'(gColorNum), 0);
    swEn = 1'b1;
    enterInit();

    $display("[TB] full game to win");
    repeat ($urandom_range(0, 9)) begin
      tick();
      checkOutput("initWait", int'(gColorNum), 7);
    end
    swPlay = 1'b1;
    for (int r = 1; r <= MAX_LEN; r++) begin
      playRound();
      playerTurn(-1, ok);
      if (!ok) break;
      finishRound();
    end
    tick();
    checkOutput("winHold", int'(gColorNum), 7);
    swEn = 1'b0;
    tick();
    checkOutput("abortColor", int'(gColorNum), 0);
    checkOutput("abortWon", int'(won), 0);
    swPlay = 1'b0; swEn = 1'b1;
    enterInit();

    $display("[TB] priority decode mismatch");
    guard = 0;
    nxt = lfsrStep(mdlLfsr);
    while (nxt[1:0] != 2'd3 && guard < 64) begin
      tick();
      checkOutput("initWait", int'(gColorNum), 7);
      nxt = lfsrStep(mdlLfsr);
      guard++;
    end
    swPlay = 1'b1;
    playRound();
    echoPress(0, 2, 4'b1001, ok);
    if (!ok) begin
      tick();
      checkOutput("loseHold", int'(gColorNum), 5);
    end
    swPlay = 1'b0;
    enterInit();

    $display("[TB] input timeout");
    swPlay = 1'b1;
    playRound();
    tick();
    checkOutput("inputEntry", int'(gColorNum), 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      checkOutput("timeoutWait", int'(gColorNum), 0);
    end
    tick();
    checkOutput("timeoutColor", int'(gColorNum), 5);
    checkOutput("timeoutLost", int'(lost), 1);
    swPlay = 1'b0;
    enterInit();
    swPlay = 1'b1;
    playRound();
    echoPress(0, TIMEOUT - 1, 4'(1 << (mdlSeq[0] - 1)), ok);
    checkOutput("lastCyclePressOk", int'(ok), 1);
    finishRound();
    swEn = 1'b0;
    tick();
    checkOutput("gapAbortColor", int'(gColorNum), 0);
    swPlay = 1'b0; swEn = 1'b1;
    enterInit();

    $display("[TB] random game with a wrong press");
    repeat ($urandom_range(0, 9)) tick();
    swPlay = 1'b1;
    errRound = int'($urandom_range(1, MAX_LEN));
    ok = 1'b1;
    for (int r = 1; r <= MAX_LEN; r++) begin
      playRound();
      playerTurn((r == errRound) ? int'($urandom_range(0, r - 1)) : -1, ok);
      if (!ok) break;
      finishRound();
    end
    swPlay = 1'b0;
    enterInit();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
